// File: rtl/stage_fifo_bus.sv
// ---------------------------------------------------------------------------
// stage_fifo_bus
//
// Purpose:
//   Parameterised valid/ready pipeline stage built on a circular buffer.
//   Payloads are written at the write pointer and presented from the read
//   pointer. One push and one pop can complete in the same cycle, so the
//   stage sustains one transfer per clock in steady state.
//
// Parameters:
//   WIDTH  payload width in bits (1..1024), default 32
//   DEPTH  number of entries, power of two (2..64), default 2
//
// Ports:
//   clk      in   single clock, all state updates on the rising edge
//   rst      in   asynchronous active-low reset
//   flush    in   synchronous discard of every stored entry
//   s_valid  in   upstream payload valid
//   s_ready  out  stage can accept a payload this cycle
//   s_data   in   upstream payload [WIDTH-1:0]
//   m_valid  out  head payload valid
//   m_ready  in   downstream accepts the head payload
//   m_data   out  head payload [WIDTH-1:0]
//   count    out  number of stored entries [$clog2(DEPTH):0]
//
// Configuration:
//   STAGE_FIFO_BYPASS_EN  when defined, an empty, non-flushing stage
//                         forwards s_valid/s_data straight to m_valid/m_data
//                         in the same cycle. The payload is only written to
//                         storage if the downstream does not take it. A
//                         bypassed transfer is neither a push nor a pop.
//                         When undefined, no combinational path exists from
//                         s_valid/s_data to any m_* output (1-cycle latency).
// ---------------------------------------------------------------------------
module stage_fifo_bus #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH-1:0]         s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_EMPTY = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  // Pointer advance with an explicit wrap from the last entry back to 0.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = PTR_ZERO;
    end else begin
      nxt = ptr + PTR_ONE;
    end
    return nxt;
  endfunction

  // Storage and state
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Decoded status and handshakes
  logic             empty_s;
  logic             full_s;
  logic             s_ready_s;
  logic             m_valid_s;
  logic [WIDTH-1:0] m_data_s;
  logic             bypass_s;
  logic             push_s;
  logic             pop_s;
  logic [CNT_W-1:0] count_nxt_s;

  // Occupancy decode from the registered count.
  always_comb begin
    empty_s = (count_r == CNT_EMPTY);
    full_s  = (count_r == CNT_FULL);
  end

  // Upstream ready: depends only on state, flush and reset, never on
  // s_valid or m_ready. Gating with rst drops it immediately on reset entry.
  always_comb begin
    s_ready_s = 1'b0;
    if (rst && !full_s && !flush) begin
      s_ready_s = 1'b1;
    end else begin
      s_ready_s = 1'b0;
    end
  end

  // Head presentation, optionally forwarding the upstream payload when the
  // stage is empty. A bypassed beat taken downstream is not written back.
`ifdef STAGE_FIFO_BYPASS_EN
  always_comb begin
    bypass_s = 1'b0;
    m_valid_s = 1'b0;
    m_data_s = mem_r[rd_ptr_r];
    if (empty_s && !flush && rst) begin
      bypass_s  = 1'b1;
      m_valid_s = s_valid;
      m_data_s  = s_data;
    end else begin
      bypass_s  = 1'b0;
      m_valid_s = !empty_s;
      m_data_s  = mem_r[rd_ptr_r];
    end
  end
`else
  always_comb begin
    bypass_s  = 1'b0;
    m_valid_s = !empty_s;
    m_data_s  = mem_r[rd_ptr_r];
  end
`endif

  // Transfer qualification. A pop needs real stored data, so a bypassed
  // beat never counts as a pop; a bypassed beat taken downstream is not a
  // push either. Flush cancels both.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (flush) begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end else begin
      push_s = s_valid && s_ready_s && !(bypass_s && m_ready);
      pop_s  = !empty_s && m_ready;
    end
  end

  // Next occupancy: a simultaneous push and pop leaves count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer and count registers; flush clears them at the next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_EMPTY;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_EMPTY;
    end else begin
      if (push_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      count_r <= count_nxt_s;
    end
  end

  // Payload storage: only the entry at the write pointer changes, and only
  // on a push. Contents are not reset; count/pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= s_data;
    end
  end

  // Output assignments.
  assign s_ready = s_ready_s;
  assign m_valid = m_valid_s;
  assign m_data  = m_data_s;
  assign count   = count_r;

endmodule

// File: tb/tb_stage_fifo_bus.sv
// ---------------------------------------------------------------------------
// tb_stage_fifo_bus
//
// Directed self-checking bench. Two instances are used: a DEPTH=2 stage for
// fill/drain/reset scenarios and a DEPTH=4 stage for streaming and flush.
// Expected values are hand-computed constants. Inputs change 1 ns after the
// rising edge; outputs are observed 1 ns after inputs settle.
// ---------------------------------------------------------------------------
module tb_stage_fifo_bus;

  logic        clk;
  logic        rst;

  logic        flush2, s_valid2, s_ready2, m_valid2, m_ready2;
  logic [31:0] s_data2, m_data2;
  logic [1:0]  count2;

  logic        flush4, s_valid4, s_ready4, m_valid4, m_ready4;
  logic [31:0] s_data4, m_data4;
  logic [2:0]  count4;

  int checks;
  int errors;

  stage_fifo_bus #(.WIDTH(32), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush2),
    .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2),
    .count(count2)
  );

  stage_fifo_bus #(.WIDTH(32), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush4),
    .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4),
    .m_valid(m_valid4), .m_ready(m_ready4), .m_data(m_data4),
    .count(count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++; if (s_ready2 !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b exp 0", s_ready2); end
    checks++; if (m_valid2 !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid2); end
    checks++; if (count2 !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count2); end
    checks++; if (count4 !== 3'd0) begin errors++; $display("FAIL reset_count4 got %0d exp 0", count4); end
    #9;
    rst = 1'b1;
    tick();
    checks++; if (s_ready2 !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready got %b exp 1", s_ready2); end
    checks++; if (s_ready4 !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready4 got %b exp 1", s_ready4); end
  endtask

  task automatic test_fill_drain();
    m_ready2 = 1'b0;
    s_valid2 = 1'b1; s_data2 = 32'h0000_00A5;
    tick();
    checks++; if (m_valid2 !== 1'b1 || m_data2 !== 32'h0000_00A5) begin errors++; $display("FAIL latency1 got v=%b d=%h exp v=1 d=a5", m_valid2, m_data2); end
    checks++; if (count2 !== 2'd1) begin errors++; $display("FAIL fill_count1 got %0d exp 1", count2); end
    s_data2 = 32'h0000_005A;
    tick();
    // Full: further s_valid is ignored and the head must hold.
    s_data2 = 32'h0000_00FF;
    #1;
    checks++; if (count2 !== 2'd2) begin errors++; $display("FAIL full_count got %0d exp 2", count2); end
    checks++; if (s_ready2 !== 1'b0) begin errors++; $display("FAIL full_s_ready got %b exp 0", s_ready2); end
    checks++; if (m_data2 !== 32'h0000_00A5) begin errors++; $display("FAIL full_head got %h exp a5", m_data2); end
    tick();
    checks++; if (count2 !== 2'd2 || m_data2 !== 32'h0000_00A5 || m_valid2 !== 1'b1) begin errors++; $display("FAIL hold got c=%0d d=%h v=%b exp c=2 d=a5 v=1", count2, m_data2, m_valid2); end
    // Drain while full: s_ready stays low in the popping cycle.
    s_valid2 = 1'b0; m_ready2 = 1'b1;
    #1;
    checks++; if (s_ready2 !== 1'b0) begin errors++; $display("FAIL full_pop_s_ready got %b exp 0", s_ready2); end
    tick();
    checks++; if (m_data2 !== 32'h0000_005A || count2 !== 2'd1) begin errors++; $display("FAIL pop1 got d=%h c=%0d exp d=5a c=1", m_data2, count2); end
    checks++; if (s_ready2 !== 1'b1) begin errors++; $display("FAIL after_pop_s_ready got %b exp 1", s_ready2); end
    tick();
    checks++; if (count2 !== 2'd0 || m_valid2 !== 1'b0) begin errors++; $display("FAIL drained got c=%0d v=%b exp c=0 v=0", count2, m_valid2); end
    // Empty with m_ready high: nothing changes.
    tick();
    checks++; if (count2 !== 2'd0 || m_valid2 !== 1'b0) begin errors++; $display("FAIL empty_pop got c=%0d v=%b exp c=0 v=0", count2, m_valid2); end
    m_ready2 = 1'b0;
  endtask

  task automatic test_stream();
    m_ready4 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s_valid4 = 1'b1; s_data4 = 32'(k);
`ifdef STAGE_FIFO_BYPASS_EN
      #1;
      checks++; if (m_valid4 !== 1'b1 || m_data4 !== 32'(k) || count4 !== 3'd0) begin errors++; $display("FAIL stream_bypass k=%0d got v=%b d=%0d c=%0d exp v=1 d=%0d c=0", k, m_valid4, m_data4, count4, k); end
      @(posedge clk); #1;
`else
      tick();
      checks++; if (m_valid4 !== 1'b1 || m_data4 !== 32'(k) || count4 !== 3'd1) begin errors++; $display("FAIL stream k=%0d got v=%b d=%0d c=%0d exp v=1 d=%0d c=1", k, m_valid4, m_data4, count4, k); end
`endif
    end
    s_valid4 = 1'b0;
    tick();
    checks++; if (count4 !== 3'd0 || m_valid4 !== 1'b0) begin errors++; $display("FAIL stream_end got c=%0d v=%b exp c=0 v=0", count4, m_valid4); end
    m_ready4 = 1'b0;
  endtask

  task automatic test_flush();
    m_ready4 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      s_valid4 = 1'b1; s_data4 = 32'(k);
      tick();
    end
    checks++; if (count4 !== 3'd3 || m_data4 !== 32'd1) begin errors++; $display("FAIL pre_flush got c=%0d d=%0d exp c=3 d=1", count4, m_data4); end
    flush4 = 1'b1; s_valid4 = 1'b1; s_data4 = 32'd4;
    #1;
    checks++; if (s_ready4 !== 1'b0) begin errors++; $display("FAIL flush_s_ready got %b exp 0", s_ready4); end
    tick();
    flush4 = 1'b0; s_valid4 = 1'b0;
    #1;
    checks++; if (count4 !== 3'd0 || m_valid4 !== 1'b0) begin errors++; $display("FAIL post_flush got c=%0d v=%b exp c=0 v=0", count4, m_valid4); end
    s_valid4 = 1'b1; s_data4 = 32'h77;
    tick();
    s_valid4 = 1'b0;
    #1;
    checks++; if (count4 !== 3'd1 || m_data4 !== 32'h77) begin errors++; $display("FAIL after_flush_push got c=%0d d=%h exp c=1 d=77", count4, m_data4); end
    m_ready4 = 1'b1;
    tick();
    m_ready4 = 1'b0;
    checks++; if (count4 !== 3'd0) begin errors++; $display("FAIL flush_drain got %0d exp 0", count4); end
  endtask

  task automatic test_bypass();
    m_ready2 = 1'b1; s_valid2 = 1'b1; s_data2 = 32'h0000_1234;
    #1;
`ifdef STAGE_FIFO_BYPASS_EN
    checks++; if (m_valid2 !== 1'b1 || m_data2 !== 32'h0000_1234) begin errors++; $display("FAIL bypass_same_cycle got v=%b d=%h exp v=1 d=1234", m_valid2, m_data2); end
    tick();
    s_valid2 = 1'b0;
    #1;
    checks++; if (count2 !== 2'd0 || m_valid2 !== 1'b0) begin errors++; $display("FAIL bypass_count got c=%0d v=%b exp c=0 v=0", count2, m_valid2); end
`else
    checks++; if (m_valid2 !== 1'b0) begin errors++; $display("FAIL no_bypass_path got %b exp 0", m_valid2); end
    m_ready2 = 1'b0;
    tick();
    s_valid2 = 1'b0;
    #1;
    checks++; if (m_valid2 !== 1'b1 || m_data2 !== 32'h0000_1234 || count2 !== 2'd1) begin errors++; $display("FAIL buffered got v=%b d=%h c=%0d exp v=1 d=1234 c=1", m_valid2, m_data2, count2); end
    m_ready2 = 1'b1;
    tick();
    checks++; if (count2 !== 2'd0) begin errors++; $display("FAIL buffered_drain got %0d exp 0", count2); end
`endif
    m_ready2 = 1'b0;
  endtask

  task automatic test_reset_mid();
    m_ready2 = 1'b0;
    s_valid2 = 1'b1; s_data2 = 32'h11;
    tick();
    s_data2 = 32'h22;
    tick();
    checks++; if (count2 !== 2'd2) begin errors++; $display("FAIL mid_pre_count got %0d exp 2", count2); end
    m_ready2 = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (m_valid2 !== 1'b0 || s_ready2 !== 1'b0) begin errors++; $display("FAIL mid_reset_async got v=%b r=%b exp v=0 r=0", m_valid2, s_ready2); end
    checks++; if (count2 !== 2'd0) begin errors++; $display("FAIL mid_reset_count got %0d exp 0", count2); end
    @(posedge clk);
    #2;
    s_valid2 = 1'b0; m_ready2 = 1'b0;
    rst = 1'b1;
    tick();
    checks++; if (count2 !== 2'd0 || m_valid2 !== 1'b0 || s_ready2 !== 1'b1) begin errors++; $display("FAIL mid_reset_release got c=%0d v=%b r=%b exp c=0 v=0 r=1", count2, m_valid2, s_ready2); end
  endtask

  initial begin
    checks = 0; errors = 0;
    flush2 = 1'b0; s_valid2 = 1'b0; m_ready2 = 1'b0; s_data2 = 32'h0;
    flush4 = 1'b0; s_valid4 = 1'b0; m_ready4 = 1'b0; s_data4 = 32'h0;
    test_reset();
    test_fill_drain();
    test_stream();
    test_flush();
    test_bypass();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
